debounce_monitor: RTL and testbench

- Synthesisable, parametrised protocol monitor for a bank of NumChannels debouncers.
- Sits beside the debouncer array in sim and FPGA builds. Checks each channel's raw input, debounced level and tick against the timing contract.
- Reports sticky per-channel error flags, a first-error capture and a saturating error-cycle counter.
- Successor to the single-channel assertion checker: multi-channel, selectable tick mode, explicit late-response window, synthesisable status.

---
 rtl/debounce_monitor.sv | 133 +++++++++++++
 tb/tb_debounce_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_monitor.sv
// Timing-contract monitor for a bank of debouncers: sticky per-channel
// error flags, first-error capture and a saturating error-cycle counter.
module debounce_monitor #(
    parameter int unsigned ClkFreq     = 100_000_000,
    parameter int unsigned StableTime  = 10,
    parameter int unsigned Slack       = 4,
    parameter int unsigned NumChannels = 4,
    parameter int unsigned TickMode    = 0,
    parameter int unsigned CntWidth    = 16,
    localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumChannels-1:0]   sw_i,
    input  logic [NumChannels-1:0]   db_level_i,
    input  logic [NumChannels-1:0]   db_tick_i,
    input  logic                     clr_i,
    output logic [4*NumChannels-1:0] err_flags_o,
    output logic                     err_any_o,
    output logic                     first_valid_o,
    output logic [ChW-1:0]           first_ch_o,
    output logic [1:0]               first_code_o,
    output logic [CntWidth-1:0]      err_cnt_o
);

    localparam longint unsigned CounterMax =
        (64'(ClkFreq) * 64'(StableTime)) / 64'd1_000_000;
    localparam longint unsigned MaxStable = CounterMax + 64'(Slack);
    localparam int unsigned CW = (MaxStable > 0) ? $clog2(MaxStable + 1) : 1;
    localparam logic [CW-1:0] MinCnt   = CW'(CounterMax);
    localparam logic [CW-1:0] MaxCnt   = CW'(MaxStable);
    localparam logic [CW-1:0] MaxCntM1 = CW'(MaxStable - 1);
    localparam int unsigned NE = 4 * NumChannels;

    logic [NumChannels-1:0] r_sw_q;
    logic [NumChannels-1:0] r_level_q;
    logic [CW-1:0]          r_stable [NumChannels];
    logic                   r_armed;
    logic [NE-1:0]          r_flags;
    logic                   r_first_valid;
    logic [ChW-1:0]         r_first_ch;
    logic [1:0]             r_first_code;
    logic [CntWidth-1:0]    r_err_cnt;

    logic [CW-1:0]          w_stable [NumChannels];
    logic [NumChannels-1:0] w_edge;
    logic [NumChannels-1:0] w_req;
    logic [NE-1:0]          w_ev;
    logic                   w_any;
    logic [ChW-1:0]         w_sel_ch;
    logic [1:0]             w_sel_code;

    always_comb begin
        w_stable = r_stable;
        w_edge   = '0;
        w_req    = '0;
        w_ev     = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (sw_i[c] != r_sw_q[c]) begin
                w_stable[c] = '0;
            end else if (r_stable[c] != MaxCnt) begin
                w_stable[c] = r_stable[c] + CW'(1);
            end
            w_edge[c] = db_level_i[c] ^ r_level_q[c];
            w_req[c]  = (TickMode != 0) ? w_edge[c]
                                        : (db_level_i[c] & ~r_level_q[c]);
            w_ev[4*c+0] = db_tick_i[c] & ~w_req[c];
            w_ev[4*c+1] = w_req[c] & ~db_tick_i[c];
            w_ev[4*c+2] = w_edge[c] & ((db_level_i[c] != sw_i[c])
                                       | (w_stable[c] < MinCnt));
            // Late fires only on the step into saturation, once per sw run
            w_ev[4*c+3] = (sw_i[c] == r_sw_q[c])
                        & (r_stable[c] == MaxCntM1)
                        & (db_level_i[c] != sw_i[c]);
        end
        if (!r_armed) begin
            w_ev = '0;
        end
    end

    // Descending scan so the lowest channel, then lowest code, wins
    always_comb begin
        w_any      = |w_ev;
        w_sel_ch   = '0;
        w_sel_code = '0;
        for (int c = NumChannels - 1; c >= 0; c--) begin
            for (int k = 3; k >= 0; k--) begin
                if (w_ev[4*c+k]) begin
                    w_sel_ch   = ChW'(c);
                    w_sel_code = 2'(k);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_q        <= '0;
            r_level_q     <= '0;
            r_stable      <= '{default: '0};
            r_armed       <= 1'b0;
            r_flags       <= '0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
            r_first_code  <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_sw_q    <= sw_i;
            r_level_q <= db_level_i;
            r_stable  <= w_stable;
            r_armed   <= 1'b1;
            r_flags   <= (clr_i ? '0 : r_flags) | w_ev;
            if (clr_i || !r_first_valid) begin
                r_first_valid <= w_any;
                r_first_ch    <= w_sel_ch;
                r_first_code  <= w_sel_code;
            end
            if (clr_i) begin
                r_err_cnt <= {{(CntWidth-1){1'b0}}, w_any};
            end else if (w_any && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CntWidth'(1);
            end
        end
    end

    assign err_flags_o   = r_flags;
    assign err_any_o     = |r_flags;
    assign first_valid_o = r_first_valid;
    assign first_ch_o    = r_first_ch;
    assign first_code_o  = r_first_code;
    assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_debounce_monitor.sv
// Directed bench for debounce_monitor; a second instance runs TickMode=1
// on the same stimulus for the any-edge tick checks.
module tb_debounce_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] lvl;
    logic [3:0] tick;
    logic       clr;

    logic [15:0] flags0, flags1;
    logic        any0, any1;
    logic        fv0, fv1;
    logic [1:0]  fch0, fch1;
    logic [1:0]  fcode0, fcode1;
    logic [15:0] cnt0, cnt1;

    int vec;
    int miss;

    debounce_monitor #(
        .ClkFreq(1_000_000), .StableTime(10), .Slack(4),
        .NumChannels(4), .TickMode(0), .CntWidth(16)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .sw_i(sw), .db_level_i(lvl),
        .db_tick_i(tick), .clr_i(clr), .err_flags_o(flags0),
        .err_any_o(any0), .first_valid_o(fv0), .first_ch_o(fch0),
        .first_code_o(fcode0), .err_cnt_o(cnt0)
    );

    debounce_monitor #(
        .ClkFreq(1_000_000), .StableTime(10), .Slack(4),
        .NumChannels(4), .TickMode(1), .CntWidth(16)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .sw_i(sw), .db_level_i(lvl),
        .db_tick_i(tick), .clr_i(clr), .err_flags_o(flags1),
        .err_any_o(any1), .first_valid_o(fv1), .first_ch_o(fch1),
        .first_code_o(fcode1), .err_cnt_o(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] s, input logic [3:0] l);
        rst = 1'b1; sw = s; lvl = l; tick = '0; clr = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = 4'hF; lvl = 4'h5; tick = 4'hF; clr = 1'b0;
        cyc(); cyc();
        vec++; if (flags0 !== 16'h0) begin miss++;
            $display("FAIL reset_flags: got %h want 0000", flags0); end
        vec++; if (cnt0 !== 16'h0) begin miss++;
            $display("FAIL reset_cnt: got %0d want 0", cnt0); end
        vec++; if ({any0, fv0, fch0, fcode0} !== 6'b0) begin miss++;
            $display("FAIL reset_misc: got %b want 000000",
                     {any0, fv0, fch0, fcode0}); end
    endtask

    task automatic test_good_edge();
        do_reset(4'h0, 4'h0);
        sw[0] = 1'b1; cyc();
        repeat (9) cyc();
        lvl[0] = 1'b1; tick[0] = 1'b1; cyc();
        tick[0] = 1'b0; cyc();
        repeat (6) cyc();
        vec++; if (flags0 !== 16'h0) begin miss++;
            $display("FAIL good_flags: got %h want 0000", flags0); end
        vec++; if (cnt0 !== 16'h0) begin miss++;
            $display("FAIL good_cnt: got %0d want 0", cnt0); end
        vec++; if (fv0 !== 1'b0) begin miss++;
            $display("FAIL good_fv: got %b want 0", fv0); end
    endtask

    task automatic test_early();
        do_reset(4'h0, 4'h0);
        sw[0] = 1'b1; cyc();
        repeat (4) cyc();
        lvl[0] = 1'b1; tick[0] = 1'b1; cyc();
        vec++; if (flags0 !== 16'h0004) begin miss++;
            $display("FAIL early_flags: got %h want 0004", flags0); end
        vec++; if ({fv0, fch0, fcode0} !== {1'b1, 2'd0, 2'd2}) begin miss++;
            $display("FAIL early_first: got v%b ch%0d code%0d want v1 ch0 code2",
                     fv0, fch0, fcode0); end
        vec++; if (cnt0 !== 16'd1) begin miss++;
            $display("FAIL early_cnt: got %0d want 1", cnt0); end
        tick[0] = 1'b0; cyc();
        vec++; if ({any0, cnt0} !== {1'b1, 16'd1}) begin miss++;
            $display("FAIL early_hold: got any%b cnt%0d want any1 cnt1",
                     any0, cnt0); end
    endtask

    task automatic test_spurious();
        do_reset(4'h4, 4'h4);
        cyc();
        tick[2] = 1'b1; cyc();
        tick[2] = 1'b0;
        vec++; if (flags0 !== 16'h0100) begin miss++;
            $display("FAIL spur_flags: got %h want 0100", flags0); end
        vec++; if ({fv0, fch0, fcode0} !== {1'b1, 2'd2, 2'd0}) begin miss++;
            $display("FAIL spur_first: got v%b ch%0d code%0d want v1 ch2 code0",
                     fv0, fch0, fcode0); end
        vec++; if (cnt0 !== 16'd1) begin miss++;
            $display("FAIL spur_cnt: got %0d want 1", cnt0); end
    endtask

    task automatic test_late();
        do_reset(4'h0, 4'h0);
        sw[1] = 1'b1; cyc();
        repeat (13) cyc();
        vec++; if (flags0 !== 16'h0) begin miss++;
            $display("FAIL late_pre: got %h want 0000", flags0); end
        cyc();
        vec++; if (flags0 !== 16'h0080) begin miss++;
            $display("FAIL late_flags: got %h want 0080", flags0); end
        vec++; if ({fv0, fch0, fcode0} !== {1'b1, 2'd1, 2'd3}) begin miss++;
            $display("FAIL late_first: got v%b ch%0d code%0d want v1 ch1 code3",
                     fv0, fch0, fcode0); end
        repeat (5) cyc();
        vec++; if (cnt0 !== 16'd1) begin miss++;
            $display("FAIL late_once: got %0d want 1", cnt0); end
    endtask

    task automatic test_multi_clear();
        do_reset(4'h0, 4'h0);
        sw[3] = 1'b1; cyc();
        repeat (7) cyc();
        sw[1] = 1'b1; cyc();
        repeat (2) cyc();
        lvl[1] = 1'b1; tick[1] = 1'b1; lvl[3] = 1'b1; cyc();
        tick[1] = 1'b0;
        vec++; if (flags0 !== 16'h2040) begin miss++;
            $display("FAIL multi_flags: got %h want 2040", flags0); end
        vec++; if ({fv0, fch0, fcode0} !== {1'b1, 2'd1, 2'd2}) begin miss++;
            $display("FAIL multi_first: got v%b ch%0d code%0d want v1 ch1 code2",
                     fv0, fch0, fcode0); end
        vec++; if (cnt0 !== 16'd1) begin miss++;
            $display("FAIL multi_cnt: got %0d want 1", cnt0); end
        clr = 1'b1; cyc();
        clr = 1'b0;
        vec++; if ({flags0, any0, fv0, fch0, fcode0, cnt0} !== 38'h0) begin
            miss++;
            $display("FAIL clr_all: got flags%h any%b v%b ch%0d code%0d cnt%0d want all 0",
                     flags0, any0, fv0, fch0, fcode0, cnt0); end
        clr = 1'b1; tick[0] = 1'b1; cyc();
        clr = 1'b0; tick[0] = 1'b0;
        vec++; if (flags0 !== 16'h0001) begin miss++;
            $display("FAIL clrnew_flags: got %h want 0001", flags0); end
        vec++; if (cnt0 !== 16'd1) begin miss++;
            $display("FAIL clrnew_cnt: got %0d want 1", cnt0); end
        vec++; if ({fv0, fch0, fcode0} !== {1'b1, 2'd0, 2'd0}) begin miss++;
            $display("FAIL clrnew_first: got v%b ch%0d code%0d want v1 ch0 code0",
                     fv0, fch0, fcode0); end
    endtask

    task automatic test_fall_and_reset();
        do_reset(4'h0, 4'h0);
        sw[0] = 1'b1; cyc();
        repeat (9) cyc();
        lvl[0] = 1'b1; tick[0] = 1'b1; cyc();
        tick[0] = 1'b0; sw[0] = 1'b0; cyc();
        repeat (9) cyc();
        lvl[0] = 1'b0; cyc();
        vec++; if ({flags0, cnt0} !== 32'h0) begin miss++;
            $display("FAIL fall_m0: got flags%h cnt%0d want 0000 0", flags0, cnt0); end
        vec++; if (flags1 !== 16'h0002) begin miss++;
            $display("FAIL fall_m1_flags: got %h want 0002", flags1); end
        vec++; if ({fv1, fch1, fcode1, cnt1} !== {1'b1, 2'd0, 2'd1, 16'd1}) begin
            miss++;
            $display("FAIL fall_m1_first: got v%b ch%0d code%0d cnt%0d want v1 ch0 code1 cnt1",
                     fv1, fch1, fcode1, cnt1); end
        sw[0] = 1'b1; cyc();
        repeat (3) cyc();
        tick[1] = 1'b1; cyc();
        tick[1] = 1'b0;
        vec++; if (flags0 !== 16'h0010) begin miss++;
            $display("FAIL prerst_flags: got %h want 0010", flags0); end
        lvl[0] = 1'b1; rst = 1'b1; cyc();
        vec++; if ({flags0, fv0, cnt0, flags1} !== 49'h0) begin miss++;
            $display("FAIL midrst: got f0 %h v%b c%0d f1 %h want zeros",
                     flags0, fv0, cnt0, flags1); end
        rst = 1'b0; cyc();
        vec++; if ({flags0, flags1} !== 32'h0) begin miss++;
            $display("FAIL postrst1: got f0 %h f1 %h want 0000 0000",
                     flags0, flags1); end
        cyc();
        vec++; if ({flags0, flags1, cnt0, cnt1} !== 64'h0) begin miss++;
            $display("FAIL postrst2: got f0 %h f1 %h c0 %0d c1 %0d want zeros",
                     flags0, flags1, cnt0, cnt1); end
    endtask

    initial begin
        vec = 0; miss = 0;
        rst = 1'b1; sw = '0; lvl = '0; tick = '0; clr = 1'b0;
        test_reset();
        test_good_edge();
        test_early();
        test_spurious();
        test_late();
        test_multi_clear();
        test_fall_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
